// File: rtl/branch_flush_ctrl.sv
// Branch pipe sequencing controller: tracks one outstanding branch, samples its resolution,
// and drives PC redirect and flush. Optional performance counters under `BRANCH_PERF_CNT_EN.
module branch_flush_ctrl #(
    parameter int PC_W         = 8,
    parameter int BR_LAT       = 2,
    parameter int FLUSH_CYCLES = 3,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             br_issue,
    input  logic             branch_taken,
    input  logic [PC_W-1:0]  pc_wb,
    output logic             br_stall,
    output logic             pc_redirect,
    output logic [PC_W-1:0]  pc_target,
    output logic             flush,
    output logic             err,
    output logic [CNT_W-1:0] taken_cnt,
    output logic [CNT_W-1:0] resolved_cnt
);

    typedef enum logic [1:0] {IDLE, WAIT, REDIRECT, DRAIN} state_t;

    localparam logic [3:0] LAT_LOAD   = 4'(BR_LAT - 1);
    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

    state_t     state, state_d;
    logic [3:0] lat_cnt, lat_cnt_d;
    logic [3:0] fl_cnt, fl_cnt_d;
    logic       sample;
    logic       sample_taken;

    // The resolution window is the single WAIT cycle where the latency counter has run out.
    assign sample       = (state == WAIT) && (lat_cnt == 4'd0);
    assign sample_taken = sample && branch_taken;

    // NOTE: every variable is given a default before the case so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        state_d   = state;
        lat_cnt_d = lat_cnt;
        fl_cnt_d  = fl_cnt;
        unique case (state)
            IDLE: begin
                if (br_issue) begin
                    state_d   = WAIT;
                    lat_cnt_d = LAT_LOAD;
                end
            end
            WAIT: begin
                if (lat_cnt == 4'd0) state_d = branch_taken ? REDIRECT : IDLE;
                else                 lat_cnt_d = lat_cnt - 4'd1;
            end
            REDIRECT: begin
                fl_cnt_d = FLUSH_LOAD;
                state_d  = (FLUSH_CYCLES == 1) ? IDLE : DRAIN;
            end
            DRAIN: begin
                fl_cnt_d = fl_cnt - 4'd1;
                if (fl_cnt <= 4'd1) state_d = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            lat_cnt     <= 4'd0;
            fl_cnt      <= 4'd0;
            br_stall    <= 1'b0;
            pc_redirect <= 1'b0;
            flush       <= 1'b0;
            pc_target   <= '0;
            err         <= 1'b0;
        end else begin
            state       <= state_d;
            lat_cnt     <= lat_cnt_d;
            fl_cnt      <= fl_cnt_d;
            // Outputs are decoded from the next state so they line up with the state they describe.
            br_stall    <= (state_d != IDLE);
            pc_redirect <= (state_d == REDIRECT);
            flush       <= (state_d == REDIRECT) || (state_d == DRAIN);
            if (sample_taken) pc_target <= pc_wb;
            if ((br_issue && state != IDLE) || (branch_taken && !sample)) err <= 1'b1;
        end
    end

`ifdef BRANCH_PERF_CNT_EN
    logic [CNT_W-1:0] taken_q, resolved_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            taken_q    <= '0;
            resolved_q <= '0;
        end else if (sample) begin
            if (resolved_q != '1)                 resolved_q <= resolved_q + CNT_W'(1);
            if (branch_taken && taken_q != '1)    taken_q    <= taken_q + CNT_W'(1);
        end
    end

    assign taken_cnt    = taken_q;
    assign resolved_cnt = resolved_q;
`else
    assign taken_cnt    = '0;
    assign resolved_cnt = '0;
`endif

endmodule

// File: tb/tb_branch_flush_ctrl.sv
// Directed testbench for branch_flush_ctrl: default-parameter instance plus a
// BR_LAT=1 / FLUSH_CYCLES=1 / CNT_W=2 instance for the sweep and counter saturation.
module tb_branch_flush_ctrl;

`ifdef BRANCH_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;

    logic        br_issue = 1'b0, branch_taken = 1'b0;
    logic [7:0]  pc_wb = '0;
    logic        br_stall, pc_redirect, flush, err;
    logic [7:0]  pc_target;
    logic [15:0] taken_cnt, resolved_cnt;

    logic        s_issue = 1'b0, s_taken = 1'b0;
    logic [7:0]  s_pc = '0;
    logic        s_stall, s_redirect, s_flush, s_err;
    logic [7:0]  s_target;
    logic [1:0]  s_taken_cnt, s_resolved_cnt;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    branch_flush_ctrl u_dut (
        .clk(clk), .reset(reset), .br_issue(br_issue), .branch_taken(branch_taken),
        .pc_wb(pc_wb), .br_stall(br_stall), .pc_redirect(pc_redirect), .pc_target(pc_target),
        .flush(flush), .err(err), .taken_cnt(taken_cnt), .resolved_cnt(resolved_cnt)
    );

    branch_flush_ctrl #(.PC_W(8), .BR_LAT(1), .FLUSH_CYCLES(1), .CNT_W(2)) u_small (
        .clk(clk), .reset(reset), .br_issue(s_issue), .branch_taken(s_taken),
        .pc_wb(s_pc), .br_stall(s_stall), .pc_redirect(s_redirect), .pc_target(s_target),
        .flush(s_flush), .err(s_err), .taken_cnt(s_taken_cnt), .resolved_cnt(s_resolved_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int c);
        while (cyc < c) step();
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s @cyc%0d: got %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        br_issue = 1'b0; branch_taken = 1'b0; pc_wb = '0;
        s_issue = 1'b0; s_taken = 1'b0; s_pc = '0;
        step();
        step();
        reset = 1'b0;
        cyc = 0;
    endtask

    initial begin
        // Reset values
        #1;
        check("rst_stall", br_stall, 0);
        check("rst_redirect", pc_redirect, 0);
        check("rst_flush", flush, 0);
        check("rst_target", pc_target, 0);
        check("rst_err", err, 0);
        check("rst_taken_cnt", taken_cnt, 0);
        check("rst_resolved_cnt", resolved_cnt, 0);

        // Taken branch: issue @5, resolve @7 with 0x3C
        do_reset();
        run_to(5);
        check("A_stall5", br_stall, 0);
        br_issue = 1'b1;
        step();                                    // 6
        br_issue = 1'b0;
        check("A_stall6", br_stall, 1);
        check("A_flush6", flush, 0);
        step();                                    // 7
        check("A_stall7", br_stall, 1);
        check("A_redirect7", pc_redirect, 0);
        branch_taken = 1'b1; pc_wb = 8'h3C;
        step();                                    // 8
        branch_taken = 1'b0; pc_wb = 8'hFF;
        check("A_redirect8", pc_redirect, 1);
        check("A_flush8", flush, 1);
        check("A_stall8", br_stall, 1);
        check("A_target8", pc_target, 8'h3C);
        step();                                    // 9
        check("A_redirect9", pc_redirect, 0);
        check("A_flush9", flush, 1);
        step();                                    // 10
        check("A_flush10", flush, 1);
        check("A_stall10", br_stall, 1);
        step();                                    // 11
        check("A_flush11", flush, 0);
        check("A_stall11", br_stall, 0);
        check("A_target11", pc_target, 8'h3C);
        check("A_err", err, 0);
        check("A_taken_cnt", taken_cnt, PERF ? 1 : 0);
        check("A_resolved_cnt", resolved_cnt, PERF ? 1 : 0);

        // Not-taken branch, then back-to-back issue @8
        do_reset();
        run_to(5);
        br_issue = 1'b1;
        step();                                    // 6
        br_issue = 1'b0;
        check("B_stall6", br_stall, 1);
        step();                                    // 7
        check("B_stall7", br_stall, 1);
        branch_taken = 1'b0; pc_wb = 8'h77;
        step();                                    // 8
        check("B_stall8", br_stall, 0);
        check("B_redirect8", pc_redirect, 0);
        check("B_flush8", flush, 0);
        br_issue = 1'b1;
        step();                                    // 9
        br_issue = 1'b0;
        check("B_stall9", br_stall, 1);
        check("B_err9", err, 0);
        step();                                    // 10 (second sample, not taken)
        step();                                    // 11
        check("B_stall11", br_stall, 0);
        check("B_flush11", flush, 0);
        check("B_target11", pc_target, 0);
        check("B_err11", err, 0);
        check("B_taken_cnt", taken_cnt, 0);
        check("B_resolved_cnt", resolved_cnt, PERF ? 2 : 0);

        // Double issue @5,@6: second ignored, err from @7, resolution still @7
        do_reset();
        run_to(5);
        br_issue = 1'b1;
        step();                                    // 6
        check("C_err6", err, 0);
        step();                                    // 7
        br_issue = 1'b0;
        check("C_err7", err, 1);
        branch_taken = 1'b1; pc_wb = 8'h21;
        step();                                    // 8
        branch_taken = 1'b0;
        check("C_redirect8", pc_redirect, 1);
        check("C_target8", pc_target, 8'h21);
        run_to(12);
        check("C_err12", err, 1);
        check("C_stall12", br_stall, 0);

        // Spurious branch_taken while IDLE
        do_reset();
        run_to(3);
        branch_taken = 1'b1;
        check("D_err3", err, 0);
        step();                                    // 4
        branch_taken = 1'b0;
        check("D_err4", err, 1);
        check("D_redirect4", pc_redirect, 0);

        // Reset asserted mid-DRAIN, then a normal branch
        do_reset();
        run_to(5);
        br_issue = 1'b1;
        step();
        br_issue = 1'b0;
        step();                                    // 7
        branch_taken = 1'b1; pc_wb = 8'h3C;
        step();                                    // 8
        branch_taken = 1'b0;
        step();                                    // 9
        check("E_flush9", flush, 1);
        #2;
        reset = 1'b1;
        #1;
        check("E_async_flush", flush, 0);
        check("E_async_stall", br_stall, 0);
        check("E_async_target", pc_target, 0);
        check("E_async_redirect", pc_redirect, 0);
        do_reset();
        run_to(2);
        check("E_idle_stall", br_stall, 0);
        br_issue = 1'b1;
        step();                                    // 3
        br_issue = 1'b0;
        step();                                    // 4
        branch_taken = 1'b1; pc_wb = 8'h55;
        step();                                    // 5
        branch_taken = 1'b0;
        check("E_redirect5", pc_redirect, 1);
        check("E_target5", pc_target, 8'h55);
        check("E_err5", err, 0);

        // BR_LAT=1 / FLUSH_CYCLES=1 sweep and CNT_W=2 saturation (5 taken branches)
        do_reset();
        for (int i = 0; i < 5; i++) begin
            run_to(2 + 3 * i);
            s_issue = 1'b1;
            step();                                // T+1: sample cycle
            s_issue = 1'b0;
            s_taken = 1'b1; s_pc = 8'h10 + 8'(i);
            check("F_stall_t1", s_stall, 1);
            step();                                // T+2
            s_taken = 1'b0;
            check("F_redirect_t2", s_redirect, 1);
            check("F_flush_t2", s_flush, 1);
            check("F_target_t2", s_target, 32'h10 + 32'(i));
            step();                                // T+3
            check("F_redirect_t3", s_redirect, 0);
            check("F_flush_t3", s_flush, 0);
            check("F_stall_t3", s_stall, 0);
        end
        check("F_err", s_err, 0);
        check("F_taken_cnt", s_taken_cnt, PERF ? 3 : 0);
        check("F_resolved_cnt", s_resolved_cnt, PERF ? 3 : 0);
        check("F_main_err", err, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
